// File: rtl/snd_io_hub.sv
// Sound I/O hub: command FIFO from the main CPU, summed DAC latches and a fractional clock enable for the speech chip.
// Optional sticky overrun flag on cmd_ovf is built in when SNDHUB_OVERRUN_FLAG_EN is defined.
module snd_io_hub #(
    parameter  int CHANNELS = 2,
    parameter  int DEPTH    = 4,
    parameter  int CMD_W    = 8,
    parameter  int CE_NUM   = 3,
    parameter  int CE_DEN   = 50,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AUD_W    = 8 + $clog2(CHANNELS),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_wr,
    input  logic [CMD_W-1:0] cmd_din,
    output logic             cmd_full,
    input  logic             cmd_rd,
    output logic [CMD_W-1:0] cmd_dout,
    output logic             cmd_irq_n,
    output logic [CNT_W-1:0] cmd_count,
    input  logic             dac_we,
    input  logic [SEL_W-1:0] dac_sel,
    input  logic [7:0]       dac_din,
    output logic [AUD_W-1:0] audio,
    output logic             spk_ce,
    output logic             cmd_ovf,
    input  logic             cmd_ovf_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ACC_W = $clog2(CE_DEN + CE_NUM + 1);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             irq_n_q, irq_n_d;
    logic             do_wr, do_rd;

    // A write while full is still accepted when the same cycle pops the head.
    always_comb begin
        do_rd    = cmd_rd && !irq_n_q;
        do_wr    = cmd_wr && (!full_q || cmd_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        irq_n_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            irq_n_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            irq_n_q  <= irq_n_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= cmd_din;
        end
    end

    assign cmd_dout  = irq_n_q ? '0 : mem_q[rd_ptr_q];
    assign cmd_full  = full_q;
    assign cmd_irq_n = irq_n_q;
    assign cmd_count = count_q;

    // ------------------------------------------------------------------
    // DAC latches and mixer
    // ------------------------------------------------------------------
    logic [7:0]       latch_q [CHANNELS];
    logic [AUD_W-1:0] audio_q, audio_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                latch_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (dac_we && (dac_sel == SEL_W'(i))) begin
                    latch_q[i] <= dac_din;
                end
            end
        end
    end

    always_comb begin
        audio_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            audio_d = audio_d + AUD_W'(latch_q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            audio_q <= '0;
        end else begin
            audio_q <= audio_d;
        end
    end

    assign audio = audio_q;

    // ------------------------------------------------------------------
    // Fractional clock enable: CE_NUM pulses every CE_DEN cycles
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic             ce_q, ce_d;

    always_comb begin
        acc_sum = acc_q + ACC_W'(CE_NUM);
        acc_d   = acc_sum;
        ce_d    = 1'b0;
        if (acc_sum >= ACC_W'(CE_DEN)) begin
            acc_d = acc_sum - ACC_W'(CE_DEN);
            ce_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign spk_ce = ce_q;

    // ------------------------------------------------------------------
    // Overrun flag
    // ------------------------------------------------------------------
`ifdef SNDHUB_OVERRUN_FLAG_EN
    logic drop_wr;
    logic ovf_q, ovf_d;

    // Set wins over a same-cycle clear so a drop is never lost.
    always_comb begin
        drop_wr = cmd_wr && full_q && !cmd_rd;
        ovf_d   = ovf_q;
        if (drop_wr) begin
            ovf_d = 1'b1;
        end else if (cmd_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign cmd_ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = cmd_ovf_clr;
    assign cmd_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_snd_io_hub.sv
// Self-checking bench for snd_io_hub: FIFO scoreboard, DAC mixer model, clock-enable rate and async reset.
// Expected overrun behaviour follows SNDHUB_OVERRUN_FLAG_EN.
module tb_snd_io_hub;

    localparam int CHANNELS = 3;
    localparam int DEPTH    = 4;
    localparam int CMD_W    = 8;
    localparam int CE_NUM   = 3;
    localparam int CE_DEN   = 50;
    localparam int SEL_W    = 2;
    localparam int AUD_W    = 10;
    localparam int CNT_W    = 3;
`ifdef SNDHUB_OVERRUN_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             cmd_wr;
    logic [CMD_W-1:0] cmd_din;
    logic             cmd_full;
    logic             cmd_rd;
    logic [CMD_W-1:0] cmd_dout;
    logic             cmd_irq_n;
    logic [CNT_W-1:0] cmd_count;
    logic             dac_we;
    logic [SEL_W-1:0] dac_sel;
    logic [7:0]       dac_din;
    logic [AUD_W-1:0] audio;
    logic             spk_ce;
    logic             cmd_ovf;
    logic             cmd_ovf_clr;

    snd_io_hub #(
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .CMD_W    (CMD_W),
        .CE_NUM   (CE_NUM),
        .CE_DEN   (CE_DEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_wr      (cmd_wr),
        .cmd_din     (cmd_din),
        .cmd_full    (cmd_full),
        .cmd_rd      (cmd_rd),
        .cmd_dout    (cmd_dout),
        .cmd_irq_n   (cmd_irq_n),
        .cmd_count   (cmd_count),
        .dac_we      (dac_we),
        .dac_sel     (dac_sel),
        .dac_din     (dac_din),
        .audio       (audio),
        .spk_ce      (spk_ce),
        .cmd_ovf     (cmd_ovf),
        .cmd_ovf_clr (cmd_ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] lat_m [CHANNELS];
    bit         ovf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_sum();
        int s = 0;
        for (int i = 0; i < CHANNELS; i++) s += int'(lat_m[i]);
        return s;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, cmd_count, 0);
        chk({tag, "_full"},  cmd_full,  0);
        chk({tag, "_irq_n"}, cmd_irq_n, 1);
        chk({tag, "_dout"},  cmd_dout,  0);
        chk({tag, "_audio"}, audio,     0);
        chk({tag, "_spk"},   spk_ce,    0);
        chk({tag, "_ovf"},   cmd_ovf,   0);
    endtask

    // One FIFO cycle: scoreboard update, drive, then compare post-update state.
    task automatic fifo_op(input bit wr, input logic [7:0] din, input bit rd, input bit clr);
        bit         was_empty, was_full;
        logic [7:0] head;
        was_empty = (exp_q.size() == 0);
        was_full  = (exp_q.size() == DEPTH);
        if (rd && !was_empty) begin
            head = exp_q.pop_front();
            chk("pop_head", cmd_dout, head);
        end
        if (wr && (!was_full || rd)) exp_q.push_back(din);
        if (wr && was_full && !rd) ovf_m = OVF_EN;
        else if (clr) ovf_m = 1'b0;
        cmd_wr = wr; cmd_din = din; cmd_rd = rd; cmd_ovf_clr = clr;
        tick();
        cmd_wr = 1'b0; cmd_rd = 1'b0; cmd_ovf_clr = 1'b0;
        chk("count", cmd_count, exp_q.size());
        chk("full",  cmd_full,  exp_q.size() == DEPTH);
        chk("irq_n", cmd_irq_n, exp_q.size() == 0);
        chk("dout",  cmd_dout,  (exp_q.size() != 0) ? exp_q[0] : 8'h00);
        chk("ovf",   cmd_ovf,   ovf_m);
    endtask

    // One DAC strobe; audio must lag the latch by one cycle.
    task automatic dac_op(input logic [SEL_W-1:0] sel, input logic [7:0] din);
        int prev;
        prev = lat_sum();
        if (int'(sel) < CHANNELS) lat_m[sel] = din;
        dac_we = 1'b1; dac_sel = sel; dac_din = din;
        tick();
        dac_we = 1'b0;
        chk("audio_lag", audio, prev);
        tick();
        chk("audio", audio, lat_sum());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first, pulses, adj;
        bit prev;
        reset = 1'b1;
        cmd_wr = 1'b0; cmd_din = '0; cmd_rd = 1'b0; cmd_ovf_clr = 1'b0;
        dac_we = 1'b0; dac_sel = '0; dac_din = '0;
        ovf_m = 1'b0;
        for (int i = 0; i < CHANNELS; i++) lat_m[i] = 8'h00;
        repeat (3) tick();
        chk_reset_vals("rst");

        // Clock-enable rate from a fresh release
        #3 reset = 1'b0;
        first = 0; pulses = 0; adj = 0; prev = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            tick();
            if (spk_ce) begin
                pulses++;
                if (first == 0) first = k;
                if (prev) adj++;
            end
            prev = spk_ce;
        end
        chk("ce_first",    first,  17);
        chk("ce_pulses",   pulses, 300);
        chk("ce_adjacent", adj,    0);

        // Basic ordering and empty read
        fifo_op(1, 8'h11, 0, 0);
        fifo_op(1, 8'h22, 0, 0);
        fifo_op(1, 8'h33, 0, 0);
        fifo_op(0, 8'h00, 1, 0);
        fifo_op(0, 8'h00, 1, 0);
        fifo_op(0, 8'h00, 1, 0);
        fifo_op(0, 8'h00, 1, 0);

        // Full, dropped write, overrun flag set/clear/priority
        for (int i = 0; i < DEPTH; i++) fifo_op(1, 8'hA0 + 8'(i), 0, 0);
        fifo_op(1, 8'h55, 0, 0);
        fifo_op(0, 8'h00, 0, 1);
        fifo_op(1, 8'h56, 0, 1);
        fifo_op(0, 8'h00, 0, 1);

        // Read+write while full, then drain across the wrap
        fifo_op(1, 8'h66, 1, 0);
        for (int i = 0; i < DEPTH; i++) fifo_op(0, 8'h00, 1, 0);

        // Read+write while empty and at occupancy 1
        fifo_op(1, 8'h99, 1, 0);
        fifo_op(1, 8'h9A, 1, 0);
        fifo_op(0, 8'h00, 1, 0);

        // Mixer
        dac_op(2'd0, 8'hFF);
        dac_op(2'd1, 8'hFF);
        chk("audio_1fe", audio, 10'h1FE);
        dac_op(2'd3, 8'h12);
        dac_op(2'd2, 8'h01);
        dac_op(2'd1, 8'h10);

        // Asynchronous reset mid-cycle with words queued
        fifo_op(1, 8'h77, 0, 0);
        fifo_op(1, 8'h88, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        exp_q.delete();
        for (int i = 0; i < CHANNELS; i++) lat_m[i] = 8'h00;
        ovf_m = 1'b0;
        tick();
        #3 reset = 1'b0;
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (spk_ce && first == 0) first = k;
        end
        chk("rst_ce_first", first,     17);
        chk("rst_count",    cmd_count, 0);
        chk("rst_irq_n",    cmd_irq_n, 1);
        chk("rst_audio",    audio,     0);
        fifo_op(1, 8'h42, 0, 0);
        fifo_op(0, 8'h00, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
